// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a load-use interlock.
// Inserts STALL_CYCLES bubbles per hazard and squashes the ID slot on flush.
module id_ex_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [6:0]        muxctrl_in,
  input  logic [2:0]        memctrl_in,
  input  logic [4:0]        aluctrl_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              flush,
  output logic              valid_out,
  output logic [6:0]        muxctrl_out,
  output logic [2:0]        memctrl_out,
  output logic [4:0]        aluctrl_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_W-1:0]  rs_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic {RUN, BUBBLE} state_t;

  // Remaining-bubble counter only needs to hold STALL_CYCLES-1.
  localparam int SC_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [SC_W-1:0] CNT_INIT = SC_W'(STALL_CYCLES - 1);
  localparam logic [SC_W-1:0] CNT_ONE  = SC_W'(1);

  state_t          state, state_next;
  logic [SC_W-1:0] cnt, cnt_next;
  logic            hazard;
  logic            load_bubble;

  assign hazard = (state == RUN) && valid_out && memctrl_out[2] && (rt_out != '0) &&
                  valid_in && ((rt_out == rs_in) || (rt_out == rt_in));
  assign stall       = !reset && !flush && (hazard || (state == BUBBLE));
  assign load_bubble = flush || stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = RUN;
      cnt_next   = '0;
    end else if (state == RUN) begin
      if (hazard && (STALL_CYCLES > 1)) begin
        state_next = BUBBLE;
        cnt_next   = CNT_INIT;
      end
    end else begin
      cnt_next = cnt - CNT_ONE;
      if (cnt == CNT_ONE) state_next = RUN;
    end
  end

  // A bubble clears every field, so EX sees an all-zero instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      muxctrl_out  <= '0;
      memctrl_out  <= '0;
      aluctrl_out  <= '0;
      rd1_out      <= '0;
      rd2_out      <= '0;
      imm_out      <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
      bubble_count <= '0;
    end else if (load_bubble) begin
      valid_out    <= 1'b0;
      muxctrl_out  <= '0;
      memctrl_out  <= '0;
      aluctrl_out  <= '0;
      rd1_out      <= '0;
      rd2_out      <= '0;
      imm_out      <= '0;
      rs_out       <= '0;
      rt_out       <= '0;
      rd_out       <= '0;
      if (bubble_count != '1) bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      valid_out    <= valid_in;
      muxctrl_out  <= muxctrl_in;
      memctrl_out  <= memctrl_in;
      aluctrl_out  <= aluctrl_in;
      rd1_out      <= rd1_in;
      rd2_out      <= rd2_in;
      imm_out      <= imm_in;
      rs_out       <= rs_in;
      rt_out       <= rt_in;
      rd_out       <= rd_in;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: three configurations share one stimulus bus,
// the unselected ones are held in reset, and a monitor compares against a queue.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [6:0]  mux;
    logic [2:0]  mem;
    logic [4:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } slot_t;

  typedef struct packed {
    slot_t       slot;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  slot_t       din;
  int          sel;
  logic [2:0]  rst_v;
  wire slot_t  o_a, o_b, o_c;
  logic        st_a, st_b, st_c;
  logic [15:0] bc_a, bc_b;
  logic [1:0]  bc_c;
  slot_t       cur_out;
  logic        cur_stall;
  logic [15:0] cur_bc;

  bit   stall_q[$];
  exp_t out_q[$];
  int   compared;
  int   mismatched;

  // Reference state: what sits in EX, stall cycles still owed, bubble tally.
  slot_t m_ex;
  int    m_pending;
  int    m_count;
  int    m_sc;
  int    m_max;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) rst_v[i] = (sel == i) ? reset : 1'b1;
  end

  always_comb begin
    cur_out   = o_a;
    cur_stall = st_a;
    cur_bc    = bc_a;
    case (sel)
      1: begin cur_out = o_b; cur_stall = st_b; cur_bc = bc_b; end
      2: begin cur_out = o_c; cur_stall = st_c; cur_bc = {14'b0, bc_c}; end
      default: ;
    endcase
  end

  id_ex_stage #(.DATA_W(32), .REG_W(5), .STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_v[0]), .valid_in(din.valid), .muxctrl_in(din.mux),
    .memctrl_in(din.mem), .aluctrl_in(din.alu), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .rs_in(din.rs), .rt_in(din.rt), .rd_in(din.rd), .flush(flush),
    .valid_out(o_a.valid), .muxctrl_out(o_a.mux), .memctrl_out(o_a.mem),
    .aluctrl_out(o_a.alu), .rd1_out(o_a.rd1), .rd2_out(o_a.rd2), .imm_out(o_a.imm),
    .rs_out(o_a.rs), .rt_out(o_a.rt), .rd_out(o_a.rd), .stall(st_a), .bubble_count(bc_a)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .reset(rst_v[1]), .valid_in(din.valid), .muxctrl_in(din.mux),
    .memctrl_in(din.mem), .aluctrl_in(din.alu), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .rs_in(din.rs), .rt_in(din.rt), .rd_in(din.rd), .flush(flush),
    .valid_out(o_b.valid), .muxctrl_out(o_b.mux), .memctrl_out(o_b.mem),
    .aluctrl_out(o_b.alu), .rd1_out(o_b.rd1), .rd2_out(o_b.rd2), .imm_out(o_b.imm),
    .rs_out(o_b.rs), .rt_out(o_b.rt), .rd_out(o_b.rd), .stall(st_b), .bubble_count(bc_b)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .STALL_CYCLES(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(rst_v[2]), .valid_in(din.valid), .muxctrl_in(din.mux),
    .memctrl_in(din.mem), .aluctrl_in(din.alu), .rd1_in(din.rd1), .rd2_in(din.rd2),
    .imm_in(din.imm), .rs_in(din.rs), .rt_in(din.rt), .rd_in(din.rd), .flush(flush),
    .valid_out(o_c.valid), .muxctrl_out(o_c.mux), .memctrl_out(o_c.mem),
    .aluctrl_out(o_c.alu), .rd1_out(o_c.rd1), .rd2_out(o_c.rd2), .imm_out(o_c.imm),
    .rs_out(o_c.rs), .rt_out(o_c.rt), .rd_out(o_c.rd), .stall(st_c), .bubble_count(bc_c)
  );

  function automatic slot_t make_slot(input logic [2:0] mem, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [31:0] a,
                                      input logic [31:0] b);
    slot_t s;
    s       = '0;
    s.valid = 1'b1;
    s.mem   = mem;
    s.alu   = 5'b00010;
    s.rd1   = a;
    s.rd2   = b;
    s.rs    = rs;
    s.rt    = rt;
    s.rd    = 5'd3;
    return s;
  endfunction

  // Small register range so loads and their consumers collide often.
  function automatic slot_t rand_slot();
    slot_t s;
    s.valid  = ($urandom_range(0, 7) != 0);
    s.mux    = 7'($urandom);
    s.mem[2] = ($urandom_range(0, 2) == 0);
    s.mem[1] = 1'($urandom_range(0, 1));
    s.mem[0] = 1'($urandom_range(0, 1));
    s.alu    = 5'($urandom);
    s.rd1    = $urandom;
    s.rd2    = $urandom;
    s.imm    = $urandom;
    s.rs     = 5'($urandom_range(0, 3));
    s.rt     = 5'($urandom_range(0, 3));
    s.rd     = 5'($urandom);
    return s;
  endfunction

  function automatic bit model_stall(input slot_t s, input logic f, input logic r);
    if (r || f) return 1'b0;
    if (m_pending > 0) return 1'b1;
    return m_ex.valid && m_ex.mem[2] && (m_ex.rt != 5'd0) && s.valid &&
           ((m_ex.rt == s.rs) || (m_ex.rt == s.rt));
  endfunction

  // One clock: present inputs, queue the expected stall, then the expected EX contents.
  task automatic apply_stimulus(input slot_t s, input logic f, input logic r, output bit st);
    exp_t e;
    din   = s;
    flush = f;
    reset = r;
    st    = model_stall(s, f, r);
    stall_q.push_back(st);
    @(posedge clk);
    if (r) begin
      m_ex      = '0;
      m_pending = 0;
      m_count   = 0;
    end else if (f || st) begin
      m_ex = '0;
      if (f) m_pending = 0;
      else if (m_pending > 0) m_pending--;
      else m_pending = m_sc - 1;
      if (m_count < m_max) m_count++;
    end else begin
      m_ex = s;
    end
    e.slot = m_ex;
    e.cnt  = 16'(m_count);
    out_q.push_back(e);
    #1;
  endtask

  // Upstream re-presents the same instruction for as long as stall is expected.
  task automatic send(input slot_t s, input logic f);
    bit st;
    apply_stimulus(s, f, 1'b0, st);
    while (st) apply_stimulus(s, 1'b0, 1'b0, st);
  endtask

  task automatic select_dut(input int i, input int sc, input int maxc);
    bit st;
    apply_stimulus(rand_slot(), 1'b0, 1'b1, st);
    sel   = i;
    m_sc  = sc;
    m_max = maxc;
    repeat (2) apply_stimulus(rand_slot(), 1'($urandom_range(0, 1)), 1'b1, st);
  endtask

  task automatic check_output();
    bit   es;
    exp_t e;
    if (stall_q.size() > 0) begin
      es = stall_q.pop_front();
      compared++;
      if (cur_stall !== es) begin
        mismatched++;
        $display("[TB] FAIL stall dut%0d t=%0t got %b want %b", sel, $time, cur_stall, es);
      end
    end
    if (out_q.size() > 0) begin
      e = out_q.pop_front();
      compared += 2;
      if (cur_out !== e.slot) begin
        mismatched++;
        $display("[TB] FAIL ex_slot dut%0d t=%0t got %h want %h", sel, $time, cur_out, e.slot);
      end
      if (cur_bc !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL bubble_count dut%0d t=%0t got %0d want %0d", sel, $time, cur_bc, e.cnt);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_output();
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    slot_t add_i, lw8, dep8, lw0, dep0, nodep, lw4, dep4, nop;
    bit st;
    compared   = 0;
    mismatched = 0;
    sel        = 0;
    m_sc       = 1;
    m_max      = 65535;
    m_ex       = '0;
    m_pending  = 0;
    m_count    = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    din        = '0;
    add_i = make_slot(3'b001, 5'd1, 5'd2, 32'd5, 32'd7);
    lw8   = make_slot(3'b101, 5'd1, 5'd8, 32'd100, 32'd0);
    dep8  = make_slot(3'b001, 5'd8, 5'd3, 32'd11, 32'd12);
    lw0   = make_slot(3'b101, 5'd1, 5'd0, 32'd100, 32'd0);
    dep0  = make_slot(3'b001, 5'd0, 5'd0, 32'd1, 32'd2);
    nodep = make_slot(3'b001, 5'd9, 5'd10, 32'd3, 32'd4);
    lw4   = make_slot(3'b101, 5'd1, 5'd4, 32'd64, 32'd0);
    dep4  = make_slot(3'b001, 5'd2, 5'd4, 32'd9, 32'd8);
    nop   = '0;
    @(posedge clk);
    #1;

    $display("[TB] single-bubble configuration");
    repeat (2) apply_stimulus(rand_slot(), 1'($urandom_range(0, 1)), 1'b1, st);
    send(add_i, 1'b0);
    send(lw8, 1'b0);
    send(dep8, 1'b0);
    send(lw0, 1'b0);
    send(dep0, 1'b0);
    send(lw8, 1'b0);
    send(nodep, 1'b0);
    send(nop, 1'b0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) apply_stimulus(rand_slot(), 1'b0, 1'b1, st);
      else send(rand_slot(), 1'($urandom_range(0, 11) == 0));
    end

    $display("[TB] three-bubble configuration");
    select_dut(1, 3, 65535);
    send(lw4, 1'b0);
    send(dep4, 1'b0);
    send(lw4, 1'b0);
    apply_stimulus(dep4, 1'b0, 1'b0, st);
    apply_stimulus(dep4, 1'b1, 1'b0, st);
    send(nop, 1'b0);
    send(lw4, 1'b0);
    apply_stimulus(dep4, 1'b0, 1'b0, st);
    apply_stimulus(dep4, 1'b0, 1'b1, st);
    send(dep4, 1'b0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) apply_stimulus(rand_slot(), 1'b0, 1'b1, st);
      else send(rand_slot(), 1'($urandom_range(0, 11) == 0));
    end

    $display("[TB] saturating-counter configuration");
    select_dut(2, 1, 3);
    for (int n = 0; n < 5; n++) begin
      send(lw8, 1'b0);
      send(dep8, 1'b0);
    end
    for (int n = 0; n < 100; n++) send(rand_slot(), 1'($urandom_range(0, 11) == 0));

    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ((stall_q.size() != 0) || (out_q.size() != 0)) begin
      mismatched++;
      $display("[TB] FAIL drain got %0d/%0d pending want 0/0", stall_q.size(), out_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
